// File: rtl/ds_mod2_tx.sv
// Second-order delta-sigma modulator transmitter: holds one PCM sample for OSR
// bit periods and emits a 1-bit stream plus a +/-1 word for the decimator.
module ds_mod2_tx #(
    parameter int unsigned OSR   = 64,
    parameter int unsigned IN_W  = 24,
    parameter int unsigned ACC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [IN_W-1:0] s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            bit_out,
    output logic            bit_valid,
    output logic [31:0]     xout,
    output logic            frame_start,
    output logic            ovf,
    output logic            underrun,
    input  logic            clr_flags
);

    localparam int unsigned EXT_W = ACC_W + 2;
    localparam int unsigned CNT_W = $clog2(OSR);

    localparam logic signed [EXT_W-1:0] FS_EXT =
        {{(EXT_W-IN_W){1'b0}}, 1'b1, {(IN_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(OSR - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                   state_q;
    logic signed [ACC_W-1:0]  i1_q, i2_q;
    logic signed [IN_W-1:0]   x_q;
    logic [CNT_W-1:0]         cnt_q;

    logic signed [EXT_W-1:0]  fb, x_ext, i1_sum, i2_sum;
    logic signed [ACC_W-1:0]  i1_sat, i2_sat;
    logic                     i1_clip, i2_clip;
    logic                     update, wrap;

    always_comb begin
        update  = (state_q == StRun) && en;
        wrap    = update && (cnt_q == CNT_LAST);
        s_ready = (state_q == StIdle) || (en && (cnt_q == CNT_LAST));

        fb     = bit_out ? FS_EXT : -FS_EXT;
        x_ext  = EXT_W'(x_q);
        i1_sum = EXT_W'(i1_q) + x_ext - fb;

        i1_clip = (i1_sum > ACC_MAX) || (i1_sum < ACC_MIN);
        if (i1_sum > ACC_MAX) begin
            i1_sat = ACC_MAX[ACC_W-1:0];
        end else if (i1_sum < ACC_MIN) begin
            i1_sat = ACC_MIN[ACC_W-1:0];
        end else begin
            i1_sat = i1_sum[ACC_W-1:0];
        end

        // Second stage integrates the already-saturated first stage.
        i2_sum  = EXT_W'(i2_q) + EXT_W'(i1_sat) - fb;
        i2_clip = (i2_sum > ACC_MAX) || (i2_sum < ACC_MIN);
        if (i2_sum > ACC_MAX) begin
            i2_sat = ACC_MAX[ACC_W-1:0];
        end else if (i2_sum < ACC_MIN) begin
            i2_sat = ACC_MIN[ACC_W-1:0];
        end else begin
            i2_sat = i2_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            i1_q        <= '0;
            i2_q        <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            xout        <= '0;
            ovf         <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            bit_valid   <= update;
            frame_start <= update && (cnt_q == '0);

            if (state_q == StIdle) begin
                if (s_valid) begin
                    x_q     <= s_data;
                    cnt_q   <= '0;
                    state_q <= StRun;
                    xout    <= 32'hFFFF_FFFF;
                end
            end else if (en) begin
                i1_q    <= i1_sat;
                i2_q    <= i2_sat;
                bit_out <= !i2_sat[ACC_W-1];
                xout    <= i2_sat[ACC_W-1] ? 32'hFFFF_FFFF : 32'h0000_0001;
                if (wrap) begin
                    cnt_q <= '0;
                    if (s_valid) begin
                        x_q <= s_data;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            // Set takes priority over a simultaneous clear.
            ovf      <= (update && (i1_clip || i2_clip)) || (ovf && !clr_flags);
            underrun <= (wrap && !s_valid) || (underrun && !clr_flags);
        end
    end

endmodule

// File: tb/tb_ds_mod2_tx.sv
// Bench for ds_mod2_tx: cycle reference model plus directed stream checks.
module tb_ds_mod2_tx;

    localparam int     OSR  = 64;
    localparam int     IN_W = 24;
    localparam longint FS   = 64'sd8388608;

    logic clk = 1'b0;
    logic reset, en, s_valid, clr_flags;
    logic [IN_W-1:0] s_data;

    logic rdy_a, bit_a, bv_a, fs_a, ovf_a, und_a;
    logic rdy_b, bit_b, bv_b, fs_b, ovf_b, und_b;
    logic [31:0] x_a, x_b;

    logic use_b;
    logic o_rdy, o_bit, o_bv, o_fs, o_ovf, o_und;
    logic [31:0] o_x;

    always #5 clk = ~clk;

    ds_mod2_tx dut_a (
        .clk(clk), .reset(reset), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_a), .bit_out(bit_a), .bit_valid(bv_a), .xout(x_a),
        .frame_start(fs_a), .ovf(ovf_a), .underrun(und_a), .clr_flags(clr_flags)
    );

    ds_mod2_tx #(.ACC_W(26)) dut_b (
        .clk(clk), .reset(reset), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_b), .bit_out(bit_b), .bit_valid(bv_b), .xout(x_b),
        .frame_start(fs_b), .ovf(ovf_b), .underrun(und_b), .clr_flags(clr_flags)
    );

    always_comb begin
        o_rdy = use_b ? rdy_b : rdy_a;
        o_bit = use_b ? bit_b : bit_a;
        o_bv  = use_b ? bv_b  : bv_a;
        o_fs  = use_b ? fs_b  : fs_a;
        o_ovf = use_b ? ovf_b : ovf_a;
        o_und = use_b ? und_b : und_a;
        o_x   = use_b ? x_b   : x_a;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int     acc_w = 32;
    bit     m_run, m_bit, m_bv, m_fs, m_ovf, m_und;
    longint m_i1, m_i2, m_x;
    int     m_cnt;
    bit     chk_on = 1'b0;

    // Stream statistics
    int cyc = 0, n_bits, n_ones, n_fs, n_rdy, fs_bad, fs_last, fs_gap;
    bit first_bits [7];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat(longint v, output bit clip);
        longint hi, lo;
        hi   = (64'sd1 <<< (acc_w - 1)) - 1;
        lo   = -hi - 1;
        clip = (v > hi) || (v < lo);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_edge();
        longint fb;
        bit c1, c2, upd, wr;
        if (!reset) begin
            m_run = 0; m_bit = 0; m_bv = 0; m_fs = 0; m_ovf = 0; m_und = 0;
            m_i1 = 0; m_i2 = 0; m_x = 0; m_cnt = 0;
            return;
        end
        c1 = 0; c2 = 0;
        upd  = m_run && en;
        wr   = upd && (m_cnt == OSR - 1);
        m_bv = upd;
        m_fs = upd && (m_cnt == 0);
        if (!m_run) begin
            if (s_valid) begin
                m_x = longint'($signed(s_data));
                m_cnt = 0;
                m_run = 1;
            end
        end else if (en) begin
            fb    = m_bit ? FS : -FS;
            m_i1  = sat(m_i1 + m_x - fb, c1);
            m_i2  = sat(m_i2 + m_i1 - fb, c2);
            m_bit = (m_i2 >= 0);
            m_cnt = wr ? 0 : m_cnt + 1;
            if (wr && s_valid) m_x = longint'($signed(s_data));
        end
        m_ovf = (upd && (c1 || c2)) || (m_ovf && !clr_flags);
        m_und = (wr && !s_valid) || (m_und && !clr_flags);
    endtask

    task automatic cycle();
        logic [31:0] exp_x;
        @(negedge clk);
        if (chk_on) chk("s_ready", 64'(o_rdy), 64'(!m_run || (en && m_cnt == OSR - 1)));
        if (o_rdy && m_run) n_rdy++;
        if (!reset) chk_on = 1'b1;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        if (chk_on) begin
            exp_x = !m_run ? 32'h0 : (m_bit ? 32'h1 : 32'hFFFF_FFFF);
            chk("bit_valid", 64'(o_bv), 64'(m_bv));
            chk("frame_start", 64'(o_fs), 64'(m_fs));
            chk("bit_out", 64'(o_bit), 64'(m_bit));
            chk("xout", 64'(o_x), 64'(exp_x));
            chk("ovf", 64'(o_ovf), 64'(m_ovf));
            chk("underrun", 64'(o_und), 64'(m_und));
        end
        if (o_bv === 1'b1) begin
            if (n_bits < 7) first_bits[n_bits] = o_bit;
            if ((o_fs === 1'b1) != (n_bits % OSR == 0)) fs_bad++;
            if (o_fs === 1'b1) begin
                n_fs++;
                fs_gap  = cyc - fs_last;
                fs_last = cyc;
            end
            n_bits++;
            if (o_bit === 1'b1) n_ones++;
        end
    endtask

    task automatic clear_stats();
        n_bits = 0; n_ones = 0; n_fs = 0; n_rdy = 0; fs_bad = 0; fs_last = cyc; fs_gap = 0;
    endtask

    task automatic do_reset();
        reset = 0; en = 0; s_valid = 0; clr_flags = 0; s_data = '0;
        repeat (2) cycle();
        reset = 1;
        clear_stats();
    endtask

    task automatic run_bits(string tag, int target);
        int guard = 0;
        while (n_bits < target && guard < 4 * target + 200) begin
            cycle();
            guard++;
        end
        chk(tag, 64'(n_bits), 64'(target));
    endtask

    initial begin
        bit exp7 [7] = '{1, 1, 0, 1, 0, 0, 1};
        int f, zero_bv, guard;
        use_b = 0;

        // Reset values
        do_reset();
        chk("rst_s_ready", 64'(o_rdy), 64'd1);
        chk("rst_bit_valid", 64'(o_bv), 64'd0);
        chk("rst_xout", 64'(o_x), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        chk("rst_underrun", 64'(o_und), 64'd0);

        // Zero input
        s_data = '0; s_valid = 1; en = 1;
        run_bits("zero_done", 1024);
        for (int i = 0; i < 7; i++) chk("zero_first_bits", 64'(first_bits[i]), 64'(exp7[i]));
        chk("zero_ones_512", 64'(n_ones >= 510 && n_ones <= 514), 64'd1);
        chk("zero_frame_pos", 64'(fs_bad), 64'd0);
        chk("zero_frame_cnt", 64'(n_fs), 64'd16);

        // DC at half scale
        do_reset();
        s_data = 24'h400000; s_valid = 1; en = 1;
        run_bits("dc_done", 4096);
        chk("dc_ones_3072", 64'(n_ones >= 3064 && n_ones <= 3080), 64'd1);
        chk("dc_no_ovf", 64'(o_ovf), 64'd0);

        // Underrun, clear, and set-wins-over-clear
        do_reset();
        s_data = 24'h012345; s_valid = 1; en = 1;
        cycle();
        s_valid = 0;
        run_bits("und_63", 63);
        chk("und_before", 64'(o_und), 64'd0);
        run_bits("und_64", 64);
        chk("und_set", 64'(o_und), 64'd1);
        clr_flags = 1;
        cycle();
        clr_flags = 0;
        chk("und_clr", 64'(o_und), 64'd0);
        run_bits("und_cont", 127);
        clr_flags = 1;
        cycle();
        clr_flags = 0;
        chk("und_set_wins", 64'(o_und), 64'd1);

        // Backpressure: one ready cycle per OSR updates
        do_reset();
        s_valid = 1; en = 1; s_data = 24'($urandom);
        cycle();
        n_rdy = 0;
        for (int i = 0; i < 256; i++) begin
            s_data = 24'($urandom_range(0, 4194304)) - 24'd2097152;
            cycle();
        end
        chk("bp_ready_cnt", 64'(n_rdy), 64'd4);

        // Enable stall stretches the hold period
        f = n_fs; guard = 0;
        while (n_fs == f && guard < 200) begin cycle(); guard++; end
        chk("en_sync_fs", 64'(n_fs > f), 64'd1);
        repeat (20) cycle();
        en = 0; zero_bv = 0;
        repeat (10) begin
            cycle();
            if (o_bv === 1'b0) zero_bv++;
        end
        en = 1;
        chk("en_bv_low", 64'(zero_bv), 64'd10);
        f = n_fs; guard = 0;
        while (n_fs == f && guard < 200) begin cycle(); guard++; end
        chk("en_fs_gap", 64'(fs_gap), 64'd74);

        // Randomised traffic, including a reset while a sample is offered
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 99) < 85);
            s_valid   = ($urandom_range(0, 99) < 90);
            clr_flags = ($urandom_range(0, 99) < 2);
            s_data    = 24'($urandom_range(0, 4194304)) - 24'd2097152;
            if (i == 1500) begin
                reset = 0; s_valid = 1;
            end else begin
                reset = 1;
            end
            cycle();
            if (i == 1500) chk("midrst_idle", 64'(o_rdy), 64'd1);
        end
        reset = 1; clr_flags = 0;

        // Overflow on a narrow integrator at negative full scale
        use_b = 1; acc_w = 26;
        do_reset();
        s_data = 24'h800000; s_valid = 1; en = 1;
        run_bits("ovf_64", 64);
        chk("ovf_set", 64'(o_ovf), 64'd1);
        chk("ovf_no_flip", 64'(n_ones), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
